// File: rtl/alu_pkg.sv
// Shared defaults, FSM state encoding and command record helpers for the ALU issue stage.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_OPW     = 3;
    localparam int ALU_DEPTH   = 4;
    localparam int ALU_LAT_DEF = 1;
    localparam int ALU_TAGW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Command record is packed as {tag, opcode, a, b}; this returns its total width.
    function automatic int rec_width(input int width, input int opw, input int tagw);
        return tagw + opw + 2 * width;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-operand and response bus of the ALU issue stage.
// The master side is the environment (command source, ALU1, response consumer);
// the slave side is the issue stage itself.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int TAGW  = ALU_TAGW
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [OPW-1:0]   rsp_opcode;
    logic [TAGW-1:0]  rsp_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode,
               rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode,
               rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with synchronous flush; DEPTH must be a power of two >= 2.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            wr_data,
    input  logic                     pop,
    output logic [DW-1:0]            rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr];
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty & ~clr;

    // Storage array; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: queues commands, drives registered operands into a combinational ALU,
// samples its result after ALU_LAT cycles and returns it tagged on a valid/ready port.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int OPW     = ALU_OPW,
    parameter int DEPTH   = ALU_DEPTH,
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int TAGW    = ALU_TAGW
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    alu_issue_stage_if.slave       bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int RW = rec_width(WIDTH, OPW, TAGW);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t           state;
    logic [LW-1:0]    lat_cnt;
    logic [TAGW-1:0]  tag_cnt;
    logic [TAGW-1:0]  op_tag;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [OPW-1:0]   rsp_op_q;
    logic [TAGW-1:0]  rsp_tag_q;
    logic             rsp_valid_q;
    logic             run;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [RW-1:0]    rd_data;
    logic [TAGW-1:0]  nxt_tag;
    logic [OPW-1:0]   nxt_op;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;

    // cmd_ready is held low during reset and rises on the first clock after release.
    assign bus.cmd_ready = run & ~full;
    assign push          = bus.cmd_valid & bus.cmd_ready & ~clr;
    // Pop when idle, or when the current response is being accepted (back-to-back issue).
    assign pop           = ~clr & ~empty &
                           ((state == IDLE) | ((state == RESP) & bus.rsp_ready));
    assign {nxt_tag, nxt_op, nxt_a, nxt_b} = rd_data;
    assign busy          = (state != IDLE) | ~empty;

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_opcode = rsp_op_q;
    assign bus.rsp_tag    = rsp_tag_q;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .push    (push),
        .wr_data ({tag_cnt, bus.cmd_opcode, bus.cmd_a, bus.cmd_b}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // Marks the stage as out of reset so cmd_ready can assert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Issue FSM with tag counter, latency counter and the alu_*/rsp_* output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            tag_cnt      <= '0;
            op_tag       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
        end else if (clr) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            tag_cnt      <= '0;
            op_tag       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            if (push) tag_cnt <= tag_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a_q  <= nxt_a;
                        alu_b_q  <= nxt_b;
                        alu_op_q <= nxt_op;
                        op_tag   <= nxt_tag;
                        lat_cnt  <= LW'(ALU_LAT - 1);
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_op_q     <= alu_op_q;
                        rsp_tag_q    <= op_tag;
                        rsp_valid_q  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (pop) begin
                            alu_a_q  <= nxt_a;
                            alu_b_q  <= nxt_b;
                            alu_op_q <= nxt_op;
                            op_tag   <= nxt_tag;
                            lat_cnt  <= LW'(ALU_LAT - 1);
                            state    <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus random traffic,
// scored against a queue-based model of the command stream and a reference ALU1.
module tb_alu_issue_stage;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(W), .OPW(3), .TAGW(4)) bus ();

    alu_issue_stage #(
        .WIDTH   (W),
        .OPW     (3),
        .DEPTH   (4),
        .ALU_LAT (LAT),
        .TAGW    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Reference ALU1: purely combinational, indexed by opcode.
    function automatic logic [W-1:0] alu1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return W'(a < b);
        endcase
    endfunction

    assign bus.alu_result = alu1(bus.alu_opcode, bus.alu_a, bus.alu_b);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   tag;
        logic [2:0]   op;
        logic [W-1:0] res;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] model_tag = '0;
    int         cyc_n = 0;
    int         n_rsp = 0;
    int         n_push = 0;
    int         rsp_times[$];
    bit         prev_stall = 0;
    logic [W-1:0] prev_res;
    logic [3:0]   prev_tag;
    logic [2:0]   prev_op;

    // Scoreboard: sampled mid-cycle, when inputs and registered outputs are stable.
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (!rst_n || clr) begin
            exp_q.delete();
            model_tag  = '0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid",  bus.rsp_valid,  1);
                chk("hold_result", bus.rsp_result, prev_res);
                chk("hold_tag",    bus.rsp_tag,    prev_tag);
                chk("hold_opcode", bus.rsp_opcode, prev_op);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_opcode", bus.rsp_opcode, e.op);
                    chk("rsp_tag",    bus.rsp_tag,    e.tag);
                end
                rsp_times.push_back(cyc_n);
                n_rsp++;
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_res   = bus.rsp_result;
            prev_tag   = bus.rsp_tag;
            prev_op    = bus.rsp_opcode;
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.tag = model_tag;
                e.op  = bus.cmd_opcode;
                e.res = alu1(bus.cmd_opcode, bus.cmd_a, bus.cmd_b);
                exp_q.push_back(e);
                model_tag++;
                n_push++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        acc = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        for (int k = 0; k < 200; k++) begin
            acc = bus.cmd_ready;
            tick(1);
            if (acc) break;
        end
        if (!acc) chk("push_timeout", acc, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input string name);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk(name, bus.rsp_valid, 1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((busy || bus.rsp_valid || exp_q.size() != 0) && k < 1000) begin
            tick(1);
            k++;
        end
        chk({name, "_busy"}, busy, 0);
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int base;
        int push_base;
        logic [W-1:0] ra, rb;
        logic [W-1:0] s_res, s_a, s_b;
        logic [3:0]   s_tag;
        logic [2:0]   s_op;

        rst_n = 1'b0;
        clr   = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.rsp_ready  = 1'b0;
        tick(3);

        // Reset state
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_tag",    bus.rsp_tag,    0);
        chk("rst_alu_a",      bus.alu_a,      0);
        chk("rst_alu_opcode", bus.alu_opcode, 0);
        chk("rst_fifo_count", fifo_count,     0);
        chk("rst_busy",       busy,           0);
        chk("rst_cmd_ready",  bus.cmd_ready,  0);
        rst_n = 1'b1;
        tick(1);
        chk("rel_cmd_ready",  bus.cmd_ready,  1);

        // Single add with latency measurement
        push_cmd(3'd0, 32'h1234_5678, 32'hAABB_CCDD);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            tick(1);
            k++;
        end
        chk("add_latency", k, LAT + 1);
        chk("add_result",  bus.rsp_result, 32'hBCF0_2355);
        chk("add_tag",     bus.rsp_tag,    0);
        bus.rsp_ready = 1'b1;
        tick(1);
        bus.rsp_ready = 1'b0;
        tick(1);
        chk("add_done_valid", bus.rsp_valid, 0);

        // All opcodes in order, free-flowing responses
        pulse_clr();
        bus.rsp_ready = 1'b1;
        base = n_rsp;
        ra = $urandom;
        rb = $urandom;
        for (int op = 0; op < 8; op++) push_cmd(3'(op), ra, rb);
        wait_drain("allop_drain");
        chk("allop_count", n_rsp - base, 8);
        chk("allop_gap", rsp_times[rsp_times.size()-1] - rsp_times[rsp_times.size()-2], LAT + 1);

        // Fill the FIFO while the consumer stalls
        pulse_clr();
        bus.rsp_ready = 1'b0;
        base = n_rsp;
        for (int i = 0; i < 5; i++) push_cmd(3'($urandom_range(0, 7)), $urandom, $urandom);
        chk("fill_cmd_ready", bus.cmd_ready, 0);
        chk("fill_count",     fifo_count,    4);
        chk("fill_rsp_valid", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1;
        tick(1);
        bus.cmd_valid = 1'b0;
        chk("fill_reject_count", fifo_count, 4);

        // Backpressure: everything visible holds still
        s_res = bus.rsp_result;
        s_tag = bus.rsp_tag;
        s_op  = bus.alu_opcode;
        s_a   = bus.alu_a;
        s_b   = bus.alu_b;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_result", bus.rsp_result, s_res);
            chk("bp_tag",    bus.rsp_tag,    s_tag);
            chk("bp_alu_a",  bus.alu_a,      s_a);
            chk("bp_alu_b",  bus.alu_b,      s_b);
            chk("bp_alu_op", bus.alu_opcode, s_op);
        end
        bus.rsp_ready = 1'b1;
        wait_drain("fill_drain");
        chk("fill_rsp_count", n_rsp - base, 5);

        // Flush during EXEC with two queued; same-cycle push is discarded
        pulse_clr();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(3'(i), $urandom, $urandom);
        chk("flush_pre_count", fifo_count,    2);
        chk("flush_pre_valid", bus.rsp_valid, 0);
        chk("flush_pre_busy",  busy,          1);
        clr = 1'b1;
        bus.cmd_valid = 1'b1;
        tick(1);
        clr = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("flush_busy",      busy,          0);
        chk("flush_rsp_valid", bus.rsp_valid, 0);
        chk("flush_count",     fifo_count,    0);
        chk("flush_cmd_ready", bus.cmd_ready, 1);
        push_cmd(3'd4, $urandom, $urandom);
        wait_rsp_valid("flush_next_rsp");
        chk("flush_next_tag", bus.rsp_tag, 0);
        bus.rsp_ready = 1'b1;
        wait_drain("flush_drain");

        // Random traffic with random backpressure; tags wrap
        pulse_clr();
        base      = n_rsp;
        push_base = n_push;
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid  = ($urandom_range(0, 2) != 0);
            bus.cmd_opcode = 3'($urandom_range(0, 7));
            bus.cmd_a      = $urandom;
            bus.cmd_b      = $urandom;
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain("rand_drain");
        chk("rand_rsp_count", n_rsp - base, n_push - push_base);

        // Asynchronous reset while a response is pending and another is queued
        bus.rsp_ready = 1'b0;
        push_cmd(3'd1, $urandom, $urandom);
        push_cmd(3'd2, $urandom, $urandom);
        wait_rsp_valid("rst_mid_rsp");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid",  bus.rsp_valid, 0);
        chk("arst_fifo_count", fifo_count,    0);
        chk("arst_alu_a",      bus.alu_a,     0);
        chk("arst_busy",       busy,          0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("arst_cmd_ready",  bus.cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
